// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - instruction-fetch request/response handshake bundle
interface pc_seq_ctrl_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid;

   modport master (
      output ifu_req_valid,
      output ifu_req_addr,
      input  ifu_req_ready,
      input  ifu_rsp_valid
   );

   modport slave (
      input  ifu_req_valid,
      input  ifu_req_addr,
      output ifu_req_ready,
      output ifu_rsp_valid
   );
endinterface

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - fetch sequencer and next-PC arbiter for the multi-cycle core
// Optional target alignment check enabled by PC_ALIGN_CHECK_EN.
module pc_seq_ctrl #(
   parameter logic [31:0] RST_PC      = 32'h8000_0000,
   parameter int          INSTR_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   pc_seq_ctrl_if.master ifu,
   input  logic        i_commit_valid,
   input  logic        i_trap_valid,
   input  logic [31:0] i_trap_target,
   input  logic        i_mret_valid,
   input  logic [31:0] i_mret_target,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_target,
   input  logic        i_halt_req,
   output logic [31:0] o_pc_src,
   output logic        o_pc_update,
   output logic [31:0] o_cur_pc,
   output logic        o_halted
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic        o_misalign_err
`endif
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_RESP,
      S_EXEC,
      S_HALT
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_cur_pc;
   logic [31:0] r_pc_src;
   logic        r_pc_update;
   logic        r_req_valid;
   logic        r_halted;
   logic [31:0] w_seq_pc;
   logic [31:0] w_next_pc;
   logic        w_do_update;

`ifdef PC_ALIGN_CHECK_EN
   logic        r_misalign_err;
   logic        w_redirect;
   logic        w_align_fault;

   assign w_redirect     = i_trap_valid | i_mret_valid | i_br_taken;
   assign o_misalign_err = r_misalign_err;
`endif

   assign w_seq_pc = r_cur_pc + 32'(INSTR_BYTES);

   always_comb begin
      w_next_state = r_state;
      w_do_update  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      w_align_fault = 1'b0;
`endif
      if (i_trap_valid)      w_next_pc = i_trap_target;
      else if (i_mret_valid) w_next_pc = i_mret_target;
      else if (i_br_taken)   w_next_pc = i_br_target;
      else                   w_next_pc = w_seq_pc;

      case (r_state)
         S_BOOT: w_next_state = S_REQ;
         S_REQ:  if (ifu.ifu_req_ready) w_next_state = S_RESP;
         S_RESP: if (ifu.ifu_rsp_valid) w_next_state = S_EXEC;
         S_EXEC: begin
            if (i_commit_valid) begin
               // A trap overrides ebreak, so halt only applies without one
               if (i_halt_req && !i_trap_valid) begin
                  w_next_state = S_HALT;
               end
`ifdef PC_ALIGN_CHECK_EN
               else if (w_redirect && (w_next_pc[1:0] != 2'b00)) begin
                  w_next_state  = S_HALT;
                  w_align_fault = 1'b1;
               end
`endif
               else begin
                  w_do_update  = 1'b1;
                  w_next_state = S_REQ;
               end
            end
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_BOOT;
         r_cur_pc    <= RST_PC;
         r_pc_src    <= RST_PC;
         r_pc_update <= 1'b0;
         r_req_valid <= 1'b0;
         r_halted    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         r_misalign_err <= 1'b0;
`endif
      end else begin
         r_state     <= w_next_state;
         r_pc_update <= w_do_update;
         r_req_valid <= (w_next_state == S_REQ);
         r_halted    <= (w_next_state == S_HALT);
         if (w_do_update) begin
            r_pc_src <= w_next_pc;
            r_cur_pc <= w_next_pc;
         end
`ifdef PC_ALIGN_CHECK_EN
         if (w_align_fault) r_misalign_err <= 1'b1;
`endif
      end
   end

   assign ifu.ifu_req_valid = r_req_valid;
   assign ifu.ifu_req_addr  = r_cur_pc;
   assign o_pc_src          = r_pc_src;
   assign o_pc_update       = r_pc_update;
   assign o_cur_pc          = r_cur_pc;
   assign o_halted          = r_halted;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch sequencer and next-PC arbiter for the multi-cycle core. It drives the PC register's `PC_src`/`valid_in` pair and owns the instruction-fetch request handshake.
- Each instruction runs through fetch request, fetch response and execute/commit.
- At commit, the block selects exactly one next-PC source (trap, mret, branch/jump, sequential) and issues a single-cycle PC update.

Parameters:
- RST_PC, 32'h8000_0000, PC value held after reset; must match the PC register's reset constant.
- INSTR_BYTES, 4, sequential increment in bytes.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- ifu_req_valid  output  1  fetch request valid.
- ifu_req_ready  input  1  fetch request accepted.
- ifu_req_addr  output  32  fetch address (current PC).
- ifu_rsp_valid  input  1  instruction word returned.
- commit_valid  input  1  current instruction finished execute/writeback.
- trap_valid  input  1  exception/ecall at commit.
- trap_target  input  32  mtvec value.
- mret_valid  input  1  mret at commit.
- mret_target  input  32  mepc value.
- br_taken  input  1  branch taken or jal/jalr at commit.
- br_target  input  32  branch/jump target.
- halt_req  input  1  ebreak at commit.
- pc_src  output  32  next PC, connects to `PC_src` on the PC register.
- pc_update  output  1  one-cycle PC write strobe, connects to `valid_in` on the PC register.
- cur_pc  output  32  PC of the instruction in flight.
- halted  output  1  core stopped.

Behaviour:
- Reset (asynchronous, immediate on rst rise, including mid-transaction):
  - state=BOOT, cur_pc=RST_PC, pc_src=RST_PC.
  - pc_update=0, ifu_req_valid=0, halted=0.
  - Any outstanding fetch is abandoned; a stale ifu_rsp_valid after reset is ignored, because only the RESP state samples it.
- FSM states: BOOT, REQ, RESP, EXEC, HALT.
- BOOT: one idle cycle after rst deasserts, then REQ.
- REQ:
  - ifu_req_valid=1, ifu_req_addr=cur_pc, held stable until ifu_req_ready=1.
  - Same-cycle valid&ready -> RESP.
- RESP: ifu_req_valid=0; waits for ifu_rsp_valid -> EXEC. A response arriving the cycle after acceptance is legal.
- EXEC waits for commit_valid. On the commit cycle:
  - Next-PC priority: trap_valid > mret_valid > br_taken > sequential.
  - Sequential next PC = cur_pc + INSTR_BYTES, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - halt_req=1 (with no trap): go to HALT. pc_update stays 0; cur_pc and pc_src are unchanged.
  - Otherwise:
    - pc_update=1 for exactly this one cycle, pc_src=selected next PC (registered output).
    - cur_pc <= selected next PC; next state REQ.
  - Simultaneous trap_valid and halt_req: the trap wins and the core does not halt.
- Latency:
  - Commit cycle N -> pc_update observed high in cycle N+1 with pc_src valid.
  - Next ifu_req_valid rises in cycle N+1, with ifu_req_addr equal to the new PC.
  - PC register and cur_pc therefore agree from N+2 onward.
- pc_update is never high outside the cycle after a commit. Redirect inputs are ignored outside EXEC.
- HALT: terminal until reset. halted=1, ifu_req_valid=0, pc_update=0.
- Outputs are all registered; none are combinational from inputs, except ifu_req_addr, which is a direct copy of cur_pc.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign_err (1 bit, resets to 0).
  - At commit, if the selected non-sequential target has bits [1:0] != 0, the block sets misalign_err=1 (sticky until reset), asserts no pc_update, and enters HALT.
- Undefined: no port. Targets are written unchecked, and the low bits propagate to the PC as-is.

Test Plan:
- Reset/boot: release rst, ready=1, rsp_valid the following cycle, commit after 2 cycles -> first ifu_req_addr=32'h8000_0000; pc_update one cycle with pc_src=32'h8000_0004.
- Backpressure: hold ifu_req_ready=0 for 5 cycles -> ifu_req_valid stays 1 and ifu_req_addr stable at 32'h8000_0004 for all 5 cycles; RESP entered only on ready.
- Priority: at commit assert trap_valid (trap_target=32'h8000_1000), mret_valid (32'h8000_2000), br_taken (32'h8000_3000) -> pc_src=32'h8000_1000. Repeat without trap -> 32'h8000_2000. Repeat without trap and mret -> 32'h8000_3000.
- Wrap: br_target=32'hFFFF_FFFC then sequential commit -> pc_src=32'h0000_0000.
- Halt and reset-mid-op: halt_req at commit -> halted=1 with no pc_update and no further requests. Separately, assert rst while in RESP, then deliver ifu_rsp_valid during reset -> outputs reset asynchronously, the response is ignored, and the refetch is from 32'h8000_0000.
- PC_ALIGN_CHECK_EN: br_target=32'h8000_0102 -> misalign_err=1, HALT, PC register not written. With the macro undefined -> pc_src=32'h8000_0102.
